mips_regfile_param: RTL and testbench
=====================================

MIPS_REGFILE_PARAM -- requirements
Module: mips_regfile_param

Interface
REQ-001 Parameters SHALL be as follows, one per line as name, default, meaning.
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W.
- NUM_RD, 2, number of read ports, minimum 1.
- ZERO_REG, 1, when 1, register 0 always reads 0 and ignores writes.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset; ports are listed below as name, direction, width, meaning.
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- init_start, in, 1, requests a full clear sweep; sampled only in IDLE.
- busy, out, 1, high while a clear sweep runs.
- we, in, 1, write enable.
- waddr, in, ADDR_W, write address.
- wdata, in, DATA_W, write data.
- rd_en, in, NUM_RD, per-port read enable.
- raddr, in, NUM_RD*ADDR_W, packed read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- rdata, out, NUM_RD*DATA_W, packed registered read data; port p occupies bits [p*DATA_W +: DATA_W].
- rvalid, out, NUM_RD, per-port read-data-valid flag.

Function
REQ-003 Storage SHALL be a DEPTH x DATA_W array; the array itself is not reset asynchronously and is cleared only by the sweep.
REQ-004 The FSM SHALL have two states, CLEAR and IDLE; reset forces CLEAR with the sweep counter at 0.
REQ-005 In CLEAR, each rising edge SHALL write 0 to the entry at the counter and then increment the counter. When the counter equals DEPTH-1, that same edge SHALL move the FSM to IDLE.
REQ-006 busy SHALL equal (state == CLEAR); after rst_n rises it stays high for exactly DEPTH rising edges.
REQ-007 In IDLE, init_start=1 at a rising edge SHALL enter CLEAR with the counter at 0; init_start is ignored while in CLEAR.
REQ-008 Writes SHALL commit at the rising edge only when we=1, state is IDLE, init_start=0, and not (ZERO_REG=1 and waddr=0). Any other write is silently dropped.
REQ-009 If init_start and we are both high in IDLE, the write SHALL be dropped and the sweep SHALL start.
REQ-010 Reads SHALL have 1-cycle latency: at the rising edge, rdata[p] loads the selected value and rvalid[p] loads rd_en[p] & ~busy & ~init_start-in-IDLE.
REQ-011 For the read selection, when ZERO_REG=1 and raddr[p]=0, the selected value SHALL be 0.
REQ-012 Otherwise, if the same edge commits a write with waddr == raddr[p], the selected value SHALL be wdata (write-first bypass).
REQ-013 Otherwise, the selected value SHALL be the array entry at raddr[p].
REQ-014 A port with rd_en[p]=0, or any port during busy, SHALL hold its previous rdata[p] and clear rvalid[p] to 0.
REQ-015 Read ports SHALL be independent; any number of ports may read the same address, including the write address, in one cycle.
REQ-016 The counter SHALL be ADDR_W bits wide and SHALL NOT wrap past DEPTH-1 in CLEAR; the exit is by the state change in REQ-005.

Reset
REQ-017 While rst_n=0, the outputs SHALL be rdata=0, rvalid=0 and busy=1, with state=CLEAR and counter=0, independent of clk.
REQ-018 Asserting reset in mid-sweep or mid-operation SHALL abort at once; the sweep restarts from entry 0 after release.
REQ-019 No write SHALL commit on the edge at which rst_n is low.

Verification
REQ-020 The bench SHALL cover the following directed scenarios (defaults unless stated).
- Reset release: busy stays high for 32 edges, then goes low. Every address read on both ports then returns 0 with rvalid=1 one cycle after rd_en.
- Write then read: write 0xDEADBEEF to reg 7, then read raddr0=7 the next cycle. rdata0=0xDEADBEEF with rvalid0=1 one edge later.
- Bypass: we=1, waddr=9, wdata=0x12345678 with raddr0=raddr1=9 in the same cycle. Both ports return 0x12345678 after the edge.
- Zero register: write 0xFFFFFFFF to reg 0 and read reg 0 on the same and next cycles. Both reads return 0; with ZERO_REG=0 the later read returns 0xFFFFFFFF.
- Collision and re-init: fill reg 3=0xA5A5A5A5, then assert init_start with we=1, waddr=4. The write to 4 is dropped, busy is high for 32 edges, and reg 3 then reads 0.
- Reset mid-sweep: pulse rst_n low at sweep edge 10. busy stays high, rdata and rvalid are 0 immediately, and busy stays high for 32 full edges after release.

Source files
------------

// File: rtl/mips_regfile_param.sv
// mips_regfile_param
// Parameterised MIPS-style register file: one write port, NUM_RD registered
// read ports with write-first bypass, optional hard-wired zero register and
// a sequential clear sweep that runs after reset or on request.

module mips_regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       init_start,
    output logic                       busy,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rvalid
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_IDLE  = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]              state;
    logic [ADDR_W-1:0]       cnt;
    logic [DATA_W-1:0]       mem [DEPTH];

    logic                    idle_op;
    logic                    wr_commit;
    logic [ADDR_W-1:0]       rd_addr   [NUM_RD];
    logic [DATA_W-1:0]       rd_sel    [NUM_RD];
    logic signed [DATA_W-1:0] rd_data_p1 [NUM_RD];
    logic [NUM_RD-1:0]       vld_p1;

    // Read selection: zero register first, then same-edge write bypass,
    // then the stored entry.
    function automatic logic [DATA_W-1:0] read_select(
        input logic [ADDR_W-1:0] addr,
        input logic              wr_hit,
        input logic [DATA_W-1:0] wr_val,
        input logic [DATA_W-1:0] mem_val
    );
        logic [DATA_W-1:0] v;
        if ((ZERO_REG != 0) && (addr == '0)) begin
            v = '0;
        end else if (wr_hit) begin
            v = wr_val;
        end else begin
            v = mem_val;
        end
        return v;
    endfunction

    assign busy    = (state == S_CLEAR);
    // An init request in IDLE takes priority over both reads and writes.
    assign idle_op = (state == S_IDLE) && !init_start;

    assign wr_commit = we && idle_op && !((ZERO_REG != 0) && (waddr == '0));

    // Per-port address unpack and read-value selection.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_addr[p] = raddr[p*ADDR_W +: ADDR_W];
            rd_sel[p]  = read_select(rd_addr[p],
                                     wr_commit && (waddr == rd_addr[p]),
                                     wdata,
                                     mem[rd_addr[p]]);
        end
    end

    // Control FSM, clear sweep and array writes; array contents survive
    // reset and are only zeroed by the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    mem[cnt] <= '0;
                    if (cnt == LAST_ADDR) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (init_start) begin
                        state <= S_CLEAR;
                        cnt   <= '0;
                    end else if (wr_commit) begin
                        mem[waddr] <= wdata;
                    end
                end
            endcase
        end
    end

    // ---- stage p1: registered read data and valid ----
    // Read registers: data loads on enabled reads outside the sweep and holds
    // otherwise; valid additionally drops while an init request is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_RD; p++) begin
                rd_data_p1[p] <= '0;
            end
            vld_p1 <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (rd_en[p] && !busy) begin
                    rd_data_p1[p] <= rd_sel[p];
                end
                vld_p1[p] <= rd_en[p] && idle_op;
            end
        end
    end

    // Pack the per-port registers onto the flat output buses.
    always_comb begin
        rdata = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rdata[p*DATA_W +: DATA_W] = rd_data_p1[p];
        end
    end

    assign rvalid = vld_p1;

endmodule

// File: tb/tb_mips_regfile_param.sv
// Testbench for mips_regfile_param: directed scenarios with a read
// scoreboard fed from a small reference model of the register file.

module tb_mips_regfile_param;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

    typedef struct {
        int          port;
        logic        vld;
        logic [31:0] data;
    } exp_t;

    logic                     clk;
    logic                     rst_n;
    logic                     init_start;
    logic                     we;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic                     busy;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rvalid;
    logic                     busy_nz;
    logic [NUM_RD*DATA_W-1:0] rdata_nz;
    logic [NUM_RD-1:0]        rvalid_nz;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_rd   [NUM_RD];
    int          edges;

    mips_regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .init_start(init_start), .busy(busy),
        .we(we), .waddr(waddr), .wdata(wdata), .rd_en(rd_en),
        .raddr(raddr), .rdata(rdata), .rvalid(rvalid)
    );

    mips_regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .init_start(init_start), .busy(busy_nz),
        .we(we), .waddr(waddr), .wdata(wdata), .rd_en(rd_en),
        .raddr(raddr), .rdata(rdata_nz), .rvalid(rvalid_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then drain the scoreboard against the registered outputs.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("rvalid%0d", e.port), 64'(rvalid[e.port]), 64'(e.vld));
            check($sformatf("rdata%0d", e.port), 64'(rdata[e.port*32 +: 32]), 64'(e.data));
        end
    endtask

    // Drive one IDLE-cycle operation, push expected reads, update the model.
    task automatic op(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic init);
        exp_t        e;
        logic [4:0]  ra [NUM_RD];
        logic        commit;
        logic [31:0] v;
        ra[0] = ra0;
        ra[1] = ra1;
        we = w; waddr = wa; wdata = wd; rd_en = re;
        raddr = {ra1, ra0};
        init_start = init;
        commit = w && !init && (wa != 5'd0);
        for (int p = 0; p < NUM_RD; p++) begin
            e.port = p;
            if (re[p] && !init) begin
                if (ra[p] == 5'd0)                v = 32'h0;
                else if (commit && wa == ra[p])   v = wd;
                else                              v = model_mem[ra[p]];
                e.vld = 1'b1;
                e.data = v;
                last_rd[p] = v;
            end else begin
                e.vld = 1'b0;
                e.data = last_rd[p];
            end
            exp_q.push_back(e);
        end
        if (commit) model_mem[wa] = wd;
        if (init) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        end
        step();
        we = 1'b0; rd_en = '0; init_start = 1'b0;
    endtask

    // Count edges until busy drops, bounded so a stuck sweep still finishes.
    task automatic count_busy(input string tag);
        edges = 0;
        while (busy && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check(tag, 64'(edges), 64'(DEPTH));
    endtask

    initial begin
        rst_n = 1'b0; init_start = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        rd_en = '0; raddr = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        for (int p = 0; p < NUM_RD; p++) last_rd[p] = 32'h0;

        // Reset state and release
        #12;
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        rst_n = 1'b1;
        count_busy("busy_after_reset");
        check("busy_low", 64'(busy), 64'd0);

        // Every address reads zero on both ports
        for (int a = 0; a < DEPTH; a++) begin
            op(1'b0, 5'd0, 32'h0, 2'b11, 5'(a), 5'(DEPTH - 1 - a), 1'b0);
        end

        // Write then read, plus hold check on the idle port
        op(1'b1, 5'd7, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0, 1'b0);
        op(1'b0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, 1'b0);
        op(1'b1, 5'd8, 32'h0BADF00D, 2'b10, 5'd1, 5'd7, 1'b0);
        op(1'b0, 5'd0, 32'h0, 2'b11, 5'd8, 5'd7, 1'b0);

        // Write-first bypass on both ports
        op(1'b1, 5'd9, 32'h12345678, 2'b11, 5'd9, 5'd9, 1'b0);
        op(1'b0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd7, 1'b0);

        // Zero register
        op(1'b1, 5'd0, 32'hFFFFFFFF, 2'b11, 5'd0, 5'd0, 1'b0);
        op(1'b0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 1'b0);
        check("nz_rdata0_reg0", 64'(rdata_nz[31:0]), 64'hFFFFFFFF);
        check("nz_rvalid0", 64'(rvalid_nz[0]), 64'd1);

        // Collision with init, then re-init sweep
        op(1'b1, 5'd3, 32'hA5A5A5A5, 2'b00, 5'd0, 5'd0, 1'b0);
        op(1'b0, 5'd0, 32'h0, 2'b01, 5'd3, 5'd0, 1'b0);
        op(1'b1, 5'd4, 32'h77777777, 2'b00, 5'd0, 5'd0, 1'b1);
        check("init_busy", 64'(busy), 64'd1);
        count_busy("busy_after_init");
        op(1'b0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd4, 1'b0);
        op(1'b0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd7, 1'b0);

        // Reset in mid-sweep
        op(1'b1, 5'd5, 32'h55555555, 2'b00, 5'd0, 5'd0, 1'b0);
        op(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, 1'b0);
        op(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("midrst_busy", 64'(busy), 64'd1);
        check("midrst_rdata", 64'(rdata), 64'd0);
        check("midrst_rvalid", 64'(rvalid), 64'd0);
        for (int p = 0; p < NUM_RD; p++) last_rd[p] = 32'h0;
        @(posedge clk);
        #1;
        check("midrst_busy_edge", 64'(busy), 64'd1);
        rst_n = 1'b1;
        count_busy("busy_after_midrst");
        op(1'b0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd31, 1'b0);
        op(1'b1, 5'd31, 32'hCAFEF00D, 2'b10, 5'd0, 5'd31, 1'b0);
        op(1'b0, 5'd0, 32'h0, 2'b01, 5'd31, 5'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
